// File: rtl/int2fp_seq_if.sv
// Handshake bundle for int2fp_seq: an integer operand goes in and a binary32 result with an inexact flag comes out.
interface int2fp_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/int2fp_seq.sv
// Purpose: 32-bit integer to binary32 converter with round-to-nearest-even; INT2FP_FAST_LZC_EN selects single-cycle normalisation.
// Latency: k+3 edges including the accept edge (k = leading zeros), 3 with INT2FP_FAST_LZC_EN, 1 for zero.
// Backpressure: one operand in flight; the result is held in DONE until out_ready, and in_ready stays low until then.
module int2fp_seq #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    int2fp_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] mag;
    logic [8:0]  exp;
    logic        sign;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_inexact;

    logic        neg_in;
    logic [31:0] abs_in;
    logic        guard;
    logic        sticky;
    logic        rnd_up;
    logic [23:0] frac_rnd;

    assign bus.in_ready    = (state == IDLE) && !rst;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_inexact = out_inexact;

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    assign neg_in = SIGNED_IN && bus.in_data[31];
    assign abs_in = neg_in ? (~bus.in_data + 32'd1) : bus.in_data;

    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign rnd_up   = guard & (sticky | mag[8]);
    assign frac_rnd = {1'b0, mag[30:8]} + {23'd0, rnd_up};

`ifdef INT2FP_FAST_LZC_EN
    logic [4:0] lzc;

    // Ascending scan so the highest set bit writes last; mag is never zero in NORM.
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) lzc = 5'(31 - i);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag         <= 32'd0;
            exp         <= 9'd0;
            sign        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == 32'd0) begin
                            out_data    <= 32'd0;
                            out_inexact <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sign  <= neg_in;
                            mag   <= abs_in;
                            exp   <= 9'd158;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
`ifdef INT2FP_FAST_LZC_EN
                    mag   <= mag << lzc;
                    exp   <= exp - {4'd0, lzc};
                    state <= ROUND;
`else
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        exp <= exp - 9'd1;
                    end else begin
                        state <= ROUND;
                    end
`endif
                end
                ROUND: begin
                    // A carry out of the rounded mantissa means 1.111..1 became 10.000..0.
                    if (frac_rnd[23]) begin
                        out_data <= {sign, 8'(exp + 9'd1), 23'd0};
                    end else begin
                        out_data <= {sign, exp[7:0], frac_rnd[22:0]};
                    end
                    out_inexact <= guard | sticky;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int2fp_seq.sv
// Bench for int2fp_seq: one signed and one unsigned instance, directed corner cases plus random operands against an arithmetic reference.
module tb_int2fp_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;          // 0 drives the signed instance, 1 the unsigned one
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int2fp_seq_if sif();
    int2fp_seq_if uif();

    assign sif.in_valid  = in_valid & ~sel;
    assign uif.in_valid  = in_valid & sel;
    assign sif.in_data   = in_data;
    assign uif.in_data   = in_data;
    assign sif.out_ready = out_ready;
    assign uif.out_ready = out_ready;

    int2fp_seq #(.SIGNED_IN(1'b1)) u_signed   (.clk(clk), .rst(rst), .bus(sif));
    int2fp_seq #(.SIGNED_IN(1'b0)) u_unsigned (.clk(clk), .rst(rst), .bus(uif));

    logic        o_in_ready, o_out_valid, o_inexact;
    logic [31:0] o_data;
    assign o_in_ready  = sel ? uif.in_ready    : sif.in_ready;
    assign o_out_valid = sel ? uif.out_valid   : sif.out_valid;
    assign o_data      = sel ? uif.out_data    : sif.out_data;
    assign o_inexact   = sel ? uif.out_inexact : sif.out_inexact;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: locate the MSB, keep 24 significant bits, round the discarded remainder to nearest-even.
    function automatic void ref_conv(input bit uns, input logic [31:0] d,
                                     output logic [31:0] r, output logic inx, output int lat);
        longint m, q, rem, half;
        bit     sg;
        int     p, sh;
        sg = !uns && d[31];
        m  = sg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
        r = 32'd0; inx = 1'b0; lat = 1;
        if (m == 0) return;
        p = 32;
        while (p > 0 && ((m >> p) & 1) == 0) p--;
`ifdef INT2FP_FAST_LZC_EN
        lat = 3;
`else
        lat = (31 - p) + 3;
`endif
        rem = 0;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        inx = (rem != 0);
        r   = {sg, 8'(127 + p), q[22:0]};
    endfunction

    task automatic convert(input logic s, input logic [31:0] d, input int bp,
                           input logic [31:0] exp_d, input logic exp_i);
        logic [31:0] rd;
        logic        ri;
        int          rl, w, lat;
        ref_conv(s, d, rd, ri, rl);
        sel = s;
        w = 0;
        #1;
        while (!o_in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", {31'd0, o_in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (bp == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 45) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid_seen", {31'd0, o_out_valid}, 32'd1);
        chk("latency", lat, rl);
        chk("out_data", o_data, exp_d);
        chk("out_inexact", {31'd0, o_inexact}, {31'd0, exp_i});
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {31'd0, o_out_valid}, 32'd1);
            chk("bp_data_held", o_data, exp_d);
            chk("bp_in_ready_low", {31'd0, o_in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop_after_hs", {31'd0, o_out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'd0, o_in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic convert_ref(input logic s, input logic [31:0] d, input int bp);
        logic [31:0] rd;
        logic        ri;
        int          rl;
        ref_conv(s, d, rd, ri, rl);
        convert(s, d, bp, rd, ri);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, sif.out_valid}, 32'd0);
        chk("rst_out_data", sif.out_data, 32'd0);
        chk("rst_out_inexact", {31'd0, sif.out_inexact}, 32'd0);
        chk("rst_in_ready_low", {31'd0, sif.in_ready}, 32'd0);
        chk("rst_out_data_u", uif.out_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, sif.in_ready}, 32'd1);

        convert(1'b0, 32'h0000_0005, 0, 32'h40A0_0000, 1'b0);
        convert(1'b0, 32'hFFFF_FFF0, 0, 32'hC180_0000, 1'b0);
        convert(1'b0, 32'h8000_0000, 0, 32'hCF00_0000, 1'b0);
        convert(1'b0, 32'h0100_0001, 0, 32'h4B80_0000, 1'b1);
        convert(1'b0, 32'h0100_0003, 0, 32'h4B80_0002, 1'b1);
        convert(1'b0, 32'h7FFF_FFFF, 0, 32'h4F00_0000, 1'b1);
        convert(1'b1, 32'hFFFF_FFFF, 0, 32'h4F80_0000, 1'b1);
        convert(1'b1, 32'h8000_0000, 0, 32'h4F00_0000, 1'b0);

        convert(1'b0, 32'h0000_0000, 5, 32'h0000_0000, 1'b0);
        convert(1'b0, 32'hFFFF_FFF0, 3, 32'hC180_0000, 1'b0);

        // Abort a long conversion with an asynchronous reset mid-normalisation.
        sel = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, sif.out_valid}, 32'd0);
        chk("abort_out_data", sif.out_data, 32'd0);
        chk("abort_in_ready", {31'd0, sif.in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_emit", {31'd0, sif.out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_after", {31'd0, sif.in_ready}, 32'd1);
        out_ready = 1'b0;
        convert(1'b0, 32'h0000_0003, 0, 32'h4040_0000, 1'b0);

        for (int i = 0; i < 120; i++) begin
            v = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            convert_ref(i[0], v, (i % 7 == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
